// File: rtl/instr_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : instr_dispatcher
// Brief    : Range-checks (dataA, dataB) instruction pairs, queues them in a
//            small FIFO and issues them to the GPU as strobe + hold windows.
// Revision : 1.0 - initial release
// ============================================================================
module instr_dispatcher #(
    parameter int DEPTH    = 4,
    parameter int AW       = 2,
    parameter int HOLD_CYC = 3,
    parameter int X_MAX    = 639,
    parameter int Y_MAX    = 479
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_push,
    input  logic [31:0]   i_dataA,
    input  logic [31:0]   i_dataB,
    input  logic          gpu_ready,
    output logic [31:0]   o_dataA,
    output logic [31:0]   o_dataB,
    output logic          o_wrReg,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count,
    output logic          o_err_range,
    output logic          o_overflow
);

    localparam int HW = (HOLD_CYC < 1) ? 1 : $clog2(HOLD_CYC + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STROBE = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [9:0]  X_LIM   = 10'(X_MAX);
    localparam logic [9:0]  Y_LIM   = 10'(Y_MAX);
    localparam logic [HW-1:0] HOLD_C = HW'(HOLD_CYC);

    logic [63:0]   mem_q [DEPTH];
    logic [63:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic [1:0]    state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [31:0]   data_a_q, data_a_d;
    logic [31:0]   data_b_q, data_b_d;
    logic          wr_reg_q, wr_reg_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;

    logic [9:0] w_x;
    logic [9:0] w_y;
    logic       w_range_bad;
    logic       w_push_ok;
    logic       w_pop;

    always_comb begin
        w_x         = i_dataB[28:19];
        w_y         = i_dataB[18:9];
        // Sprite-disable words carry no meaningful coordinates, so they always pass.
        w_range_bad = i_dataB[29] && ((w_x > X_LIM) || (w_y > Y_LIM));
        // Full is the registered flag: a pop on the same edge cannot make room.
        w_push_ok   = i_push && !w_range_bad && !full_q;
        w_pop       = (state_q == S_IDLE) && !empty_q && gpu_ready;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;

        if (w_push_ok) begin
            mem_d[wr_ptr_q] = {i_dataA, i_dataB};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (w_pop) begin
            {data_a_d, data_b_d} = mem_q[rd_ptr_q];
            rd_ptr_d             = rd_ptr_q + AW'(1);
        end

        case ({w_push_ok, w_pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);

        err_d    = i_push && w_range_bad;
        ovf_d    = i_push && !w_range_bad && full_q;
        wr_reg_d = w_pop;
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_pop) begin
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                hold_cnt_d = HOLD_C;
                state_d    = S_HOLD;
            end
            S_HOLD: begin
                // The edge that takes the counter to zero is the last hold edge.
                hold_cnt_d = hold_cnt_q - HW'(1);
                if (hold_cnt_q <= HW'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            state_q    <= S_IDLE;
            hold_cnt_q <= '0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            wr_reg_q   <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            wr_reg_q   <= wr_reg_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
        end
    end

    assign o_dataA     = data_a_q;
    assign o_dataB     = data_b_q;
    assign o_wrReg     = wr_reg_q;
    assign o_full      = full_q;
    assign o_empty     = empty_q;
    assign o_count     = count_q;
    assign o_err_range = err_q;
    assign o_overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_dispatcher
// Brief    : Scoreboard bench for instr_dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_dispatcher;

    localparam int HOLD = 3;

    logic        clk;
    logic        reset_n;
    logic        i_push;
    logic [31:0] i_dataA;
    logic [31:0] i_dataB;
    logic        gpu_ready;
    logic [31:0] o_dataA;
    logic [31:0] o_dataB;
    logic        o_wrReg;
    logic        o_full;
    logic        o_empty;
    logic [2:0]  o_count;
    logic        o_err_range;
    logic        o_overflow;

    int tests_run  = 0;
    int tests_fail = 0;
    int cyc        = 0;
    int strobes    = 0;
    int last_strobe = -1;
    bit chk_space  = 1'b0;
    logic [63:0] sb_q [$];

    instr_dispatcher #(
        .DEPTH(4), .AW(2), .HOLD_CYC(HOLD), .X_MAX(639), .Y_MAX(479)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .i_push(i_push),
        .i_dataA(i_dataA), .i_dataB(i_dataB), .gpu_ready(gpu_ready),
        .o_dataA(o_dataA), .o_dataB(o_dataB), .o_wrReg(o_wrReg),
        .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
        .o_err_range(o_err_range), .o_overflow(o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Every strobe is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (o_wrReg === 1'b1) begin
            strobes++;
            if (sb_q.size() == 0) begin
                check("unexpected_issue", {o_dataA, o_dataB}, 64'hDEAD);
            end else begin
                check("issue", {o_dataA, o_dataB}, sb_q.pop_front());
            end
            if (chk_space && last_strobe >= 0) begin
                check("spacing", 64'(cyc - last_strobe), 64'(HOLD + 2));
            end
            last_strobe = cyc;
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] b, input bit accept);
        i_push  = 1'b1;
        i_dataA = a;
        i_dataB = b;
        if (accept) sb_q.push_back({a, b});
        @(posedge clk);
        #1 i_push = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb_q.size() != 0 || o_empty !== 1'b1) && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", 64'(n >= 300), 64'd0);
        repeat (HOLD + 3) @(posedge clk);
        #1;
    endtask

    initial begin
        int s0;
        reset_n = 1'b0; i_push = 1'b0; i_dataA = '0; i_dataB = '0; gpu_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        check("rst_count", 64'(o_count), 64'd0);
        check("rst_empty", 64'(o_empty), 64'd1);
        check("rst_full",  64'(o_full),  64'd0);
        check("rst_wrreg", 64'(o_wrReg), 64'd0);
        check("rst_dataB", 64'(o_dataB), 64'd0);

        // Single push: strobe one cycle after the push edge, data held afterwards.
        gpu_ready = 1'b1;
        s0 = strobes;
        @(posedge clk); #1;
        push(32'h1, 32'h21906400, 1'b1);
        check("lat_pre", 64'(o_wrReg), 64'd0);
        @(posedge clk); #1;
        check("lat_strobe", 64'(o_wrReg), 64'd1);
        check("lat_dataB", 64'(o_dataB), 64'h21906400);
        for (int i = 0; i < HOLD; i++) begin
            @(posedge clk); #1;
            check("hold_wrreg", 64'(o_wrReg), 64'd0);
            check("hold_dataB", 64'(o_dataB), 64'h21906400);
        end
        wait_idle();
        check("single_strobes", 64'(strobes - s0), 64'd1);

        // Fill to full with the GPU stalled, then overflow.
        gpu_ready = 1'b0;
        push(32'h10, 32'h21906400, 1'b1);
        push(32'h11, 32'h21935c00, 1'b1);
        push(32'h12, 32'h32706400, 1'b1);
        push(32'h13, 32'h32735c00, 1'b1);
        check("fill_full", 64'(o_full), 64'd1);
        check("fill_count", 64'(o_count), 64'd4);
        push(32'h14, 32'h2a01e000, 1'b0);
        check("ovf_pulse", 64'(o_overflow), 64'd1);
        check("ovf_count", 64'(o_count), 64'd4);
        @(posedge clk); #1;
        check("ovf_one_cycle", 64'(o_overflow), 64'd0);
        chk_space = 1'b1; last_strobe = -1;
        s0 = strobes;
        gpu_ready = 1'b1;
        wait_idle();
        chk_space = 1'b0;
        check("drain_strobes", 64'(strobes - s0), 64'd4);
        check("drain_empty", 64'(o_empty), 64'd1);

        // Range checking.
        gpu_ready = 1'b0;
        push(32'h20, 32'h35006400, 1'b0);
        check("x_err_pulse", 64'(o_err_range), 64'd1);
        check("x_err_count", 64'(o_count), 64'd0);
        push(32'h21, 32'h2003C000, 1'b0);
        check("y_err_pulse", 64'(o_err_range), 64'd1);
        push(32'h22, 32'h20000000, 1'b1);
        check("origin_ok", 64'(o_count), 64'd1);
        check("origin_noerr", 64'(o_err_range), 64'd0);
        push(32'h23, 32'h1FF80000, 1'b1);
        check("disabled_ok", 64'(o_count), 64'd2);
        push(32'h24, 32'h3FF80000, 1'b0);
        check("x1023_err", 64'(o_err_range), 64'd1);
        gpu_ready = 1'b1;
        wait_idle();

        // Push coinciding with a pop of a full FIFO is still rejected.
        gpu_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h30 + 32'(i), 32'h20000000 + 32'(i), 1'b1);
        check("pp_full", 64'(o_full), 64'd1);
        gpu_ready = 1'b1;
        push(32'h3F, 32'h20000200, 1'b0);
        check("pp_ovf", 64'(o_overflow), 64'd1);
        check("pp_count", 64'(o_count), 64'd3);
        wait_idle();

        // Sustained traffic at the drain rate across many pointer wraps.
        chk_space = 1'b1; last_strobe = -1;
        s0 = strobes;
        for (int i = 0; i < 20; i++) begin
            push(32'h100 + 32'(i), 32'h20000000 | (32'(i * 7) << 19) | (32'(i * 3) << 9), 1'b1);
            repeat (HOLD + 1) @(posedge clk);
            #1;
        end
        wait_idle();
        chk_space = 1'b0;
        check("stream_strobes", 64'(strobes - s0), 64'd20);

        // Asynchronous reset in the middle of a HOLD window with 2 entries queued.
        push(32'h200, 32'h21906400, 1'b1);
        push(32'h201, 32'h21935c00, 1'b1);
        push(32'h202, 32'h32706400, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_count", 64'(o_count), 64'd0);
        check("arst_empty", 64'(o_empty), 64'd1);
        check("arst_wrreg", 64'(o_wrReg), 64'd0);
        check("arst_dataB", 64'(o_dataB), 64'd0);
        sb_q.delete();
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("arst_quiet", 64'(o_empty), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
`default_nettype wire
